// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: edge-latched interrupt pending bits, single-winner grant, one-cycle intr pulse, non-nesting service.
// Define ROUND_ROBIN_EN for rotating priority from rrPtr; otherwise the lowest eligible index wins.
module interrupt_arbiter #(
  parameter int NUM_SOURCES = 8,
  parameter int ID_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] VECTOR_BASE = 32'h00000100,
  parameter logic [DATA_WIDTH-1:0] VECTOR_STRIDE = 32'h00000010
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irqIn,
  input  logic [NUM_SOURCES-1:0] irqMask,
  input  logic                   intrEnable,
  input  logic                   cpuReady,
  input  logic [5:0]             memInstOpcode,
  output logic                   intr,
  output logic                   inService,
  output logic [ID_WIDTH-1:0]    activeId,
  output logic [DATA_WIDTH-1:0]  vectorAddr,
  output logic [NUM_SOURCES-1:0] pending
);
  localparam logic [5:0] RETURN_OP = 6'b101100;
  typedef enum logic {IDLE, SERVICE} state_t;
  state_t                  r_state;
  logic [NUM_SOURCES-1:0]  r_irq_prev;
  logic [NUM_SOURCES-1:0]  r_pending;
  logic                    r_intr;
  logic                    r_in_service;
  logic [ID_WIDTH-1:0]     r_active_id;
  logic [DATA_WIDTH-1:0]   r_vector_addr;
  logic [NUM_SOURCES-1:0]  w_edge;
  logic [NUM_SOURCES-1:0]  w_eligible;
  logic [NUM_SOURCES-1:0]  w_clear;
  logic [ID_WIDTH-1:0]     w_winner;
  logic [DATA_WIDTH-1:0]   w_vector;
  logic                    w_grant;
  assign w_edge     = irqIn & ~r_irq_prev;
  assign w_eligible = r_pending & ~irqMask;
  assign w_grant    = (r_state == IDLE) && intrEnable && cpuReady && (|w_eligible);
  assign w_clear    = w_grant ? ({{(NUM_SOURCES-1){1'b0}}, 1'b1} << w_winner) : '0;
  assign w_vector   = VECTOR_BASE + DATA_WIDTH'(w_winner) * VECTOR_STRIDE;
`ifdef ROUND_ROBIN_EN
  logic [ID_WIDTH-1:0] r_rr_ptr;
  // Descending scan so the smallest offset from rrPtr is the last (winning) assignment.
  always_comb begin
    int idx;
    idx = 0;
    w_winner = '0;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      idx = (idx >= NUM_SOURCES) ? idx - NUM_SOURCES : idx;
      if (w_eligible[ID_WIDTH'(idx)]) w_winner = ID_WIDTH'(idx);
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_rr_ptr <= '0;
    else if (w_grant) r_rr_ptr <= (w_winner == ID_WIDTH'(NUM_SOURCES - 1)) ? '0 : w_winner + 1'b1;
  end
`else
  always_comb begin
    w_winner = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--)
      if (w_eligible[i]) w_winner = ID_WIDTH'(i);
  end
`endif
  // A new edge is OR-ed in after the grant clear so a re-raised winner stays pending.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_irq_prev    <= '0;
      r_pending     <= '0;
      r_intr        <= 1'b0;
      r_in_service  <= 1'b0;
      r_active_id   <= '0;
      r_vector_addr <= VECTOR_BASE;
    end else begin
      r_irq_prev <= irqIn;
      r_pending  <= (r_pending & ~w_clear) | w_edge;
      r_intr     <= w_grant;
      if (w_grant) begin
        r_state       <= SERVICE;
        r_in_service  <= 1'b1;
        r_active_id   <= w_winner;
        r_vector_addr <= w_vector;
      end else if (r_state == SERVICE && memInstOpcode == RETURN_OP) begin
        r_state      <= IDLE;
        r_in_service <= 1'b0;
      end
    end
  end
  assign intr       = r_intr;
  assign inService  = r_in_service;
  assign activeId   = r_active_id;
  assign vectorAddr = r_vector_addr;
  assign pending    = r_pending;
endmodule
